// File: rtl/riscv_data_port_arbiter.sv
// riscv_data_port_arbiter
//
// Shares the core's single data-memory port between two requesters.
// Master 0 is the load/store unit. Master 1 is a secondary requester,
// such as the debug system bus or a DMA.
//
// Arbitration is round-robin. A master can take a lock so that its
// atomic or multi-beat sequence is not interleaved with the other
// master's requests. Responses come back in order. A small FIFO holds
// one ID bit per granted-but-unanswered transaction, and that bit routes
// each response back to the master that issued it.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mX_req_i .. mX_atop_i  master X request and payload (X = 0, 1)
//   mX_lock_i              master X keeps ownership after this grant
//   mX_gnt_o               zero-latency grant to master X
//   mX_rvalid_o/err_o      routed response strobe and error
//   mX_rdata_o             slave read data, driven to both masters
//   s_*                    shared slave port
//   spurious_rvalid_o      rvalid arrived with nothing outstanding
//   busy_o                 any request pending or outstanding
module riscv_data_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic        m0_lock_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [5:0]  m0_atop_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_lock_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [5:0]  m1_atop_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    output logic [5:0]  s_atop_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic        s_err_i,
    output logic        spurious_rvalid_o,
    output logic        busy_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                       r_last;
    logic                       r_lock;
    logic                       r_lock_id;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CW-1:0]              r_cnt;

    logic w_full;
    logic w_empty;
    logic w_sel;
    logic w_sel_valid;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Pointers wrap modulo the FIFO depth, which need not be a power of two.
    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_cnt == '0);

    // The full check uses the registered count. A response that frees a
    // slot therefore lets the next grant through only on the following cycle.
    always_comb begin
        w_sel       = 1'b0;
        w_sel_valid = 1'b0;
        if (!w_full) begin
            if (r_lock) begin
                if (r_lock_id ? m1_req_i : m0_req_i) begin
                    w_sel_valid = 1'b1;
                    w_sel       = r_lock_id;
                end
            end else if (m0_req_i && m1_req_i) begin
                w_sel_valid = 1'b1;
                w_sel       = ~r_last;
            end else if (m0_req_i) begin
                w_sel_valid = 1'b1;
                w_sel       = 1'b0;
            end else if (m1_req_i) begin
                w_sel_valid = 1'b1;
                w_sel       = 1'b1;
            end
        end
    end

    // w_sel stays 0 when nothing is selected, so the idle payload comes from master 0.
    assign s_req_o   = w_sel_valid;
    assign s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = w_sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = w_sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;
    assign s_atop_o  = w_sel ? m1_atop_i  : m0_atop_i;

    assign w_push   = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_push & ~w_sel;
    assign m1_gnt_o = w_push &  w_sel;

    assign w_pop  = s_rvalid_i & ~w_empty;
    assign w_head = r_fifo[r_rptr];

    assign m0_rvalid_o       = w_pop & ~w_head;
    assign m1_rvalid_o       = w_pop &  w_head;
    assign m0_err_o          = w_pop & ~w_head & s_err_i;
    assign m1_err_o          = w_pop &  w_head & s_err_i;
    assign m0_rdata_o        = s_rdata_i;
    assign m1_rdata_o        = s_rdata_i;
    assign spurious_rvalid_o = s_rvalid_i & w_empty;
    assign busy_o            = m0_req_i | m1_req_i | ~w_empty;

    // Arbitration history, lock ownership and the outstanding-ID FIFO.
    // A grant without lock_i releases any lock that was held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last    <= 1'b1;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_fifo    <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= ptrInc(r_wptr);
                r_last         <= w_sel;
                if (w_sel ? m1_lock_i : m0_lock_i) begin
                    r_lock    <= 1'b1;
                    r_lock_id <= w_sel;
                end else begin
                    r_lock <= 1'b0;
                end
            end
            if (w_pop) begin
                r_rptr <= ptrInc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_data_port_arbiter.sv
// Testbench for riscv_data_port_arbiter.
// A reference model predicts grants and the slave payload each cycle.
// A scoreboard queue holds the expected responses, and a monitor process
// compares them against the routed rvalid, err and rdata outputs.
module tb_riscv_data_port_arbiter;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mReq [2];
    logic        mLock [2];
    logic [31:0] mAddr [2];
    logic        mWe [2];
    logic [3:0]  mBe [2];
    logic [31:0] mWdata [2];
    logic [5:0]  mAtop [2];
    logic [31:0] stAddr [2];
    logic        stWe [2];
    logic [3:0]  stBe [2];
    logic [31:0] stWdata [2];
    logic [5:0]  stAtop [2];
    logic        s_gnt_i = 1'b0;
    logic        s_rvalid_i = 1'b0;
    logic [31:0] s_rdata_i = '0;
    logic        s_err_i = 1'b0;

    wire         m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    wire  [31:0] m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o;
    wire         s_req_o, s_we_o, spurious_rvalid_o, busy_o;
    wire  [3:0]  s_be_o;
    wire  [5:0]  s_atop_o;

    riscv_data_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(mReq[0]), .m0_lock_i(mLock[0]), .m0_addr_i(mAddr[0]), .m0_we_i(mWe[0]),
        .m0_be_i(mBe[0]), .m0_wdata_i(mWdata[0]), .m0_atop_i(mAtop[0]),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(mReq[1]), .m1_lock_i(mLock[1]), .m1_addr_i(mAddr[1]), .m1_we_i(mWe[1]),
        .m1_be_i(mBe[1]), .m1_wdata_i(mWdata[1]), .m1_atop_i(mAtop[1]),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_atop_o(s_atop_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .spurious_rvalid_o(spurious_rvalid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          spur;
        bit          owner;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    int    tests = 0;
    int    fails = 0;
    int    outQ[$];
    resp_t sbQ[$];
    int    lastOwner = 1;
    int    lockOwner = -1;
    bit    pend [2];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic newPayload(input int m);
        stAddr[m]  = $urandom;
        stWe[m]    = 1'($urandom);
        stBe[m]    = 4'($urandom);
        stWdata[m] = $urandom;
        stAtop[m]  = 6'($urandom);
    endtask

    // One clock cycle of stimulus, applied just after the rising edge.
    // Any response issued this cycle is predicted from the model's
    // outstanding list and queued for the monitor.
    task automatic applyStimulus(input bit r0, input bit r1, input bit l0, input bit l1,
                                 input bit gnt, input bit rv, input logic [31:0] rdata, input bit err);
        resp_t e;
        @(posedge clk_i);
        #1;
        for (int m = 0; m < 2; m++) begin
            mAddr[m]  = stAddr[m];
            mWe[m]    = stWe[m];
            mBe[m]    = stBe[m];
            mWdata[m] = stWdata[m];
            mAtop[m]  = stAtop[m];
        end
        mReq[0]    = r0;
        mReq[1]    = r1;
        mLock[0]   = l0;
        mLock[1]   = l1;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rdata;
        s_err_i    = err;
        if (rv) begin
            e.spur  = (outQ.size() == 0);
            e.owner = (outQ.size() != 0) ? outQ[0][0] : 1'b0;
            e.rdata = rdata;
            e.err   = err;
            sbQ.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && outQ.size() != 0; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, $urandom, 1'($urandom));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drain_outstanding", 128'(outQ.size()), 128'(0));
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mReq[m]  = 1'b0;
            mLock[m] = 1'b0;
            pend[m]  = 1'b0;
        end
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_err_i    = 1'b0;
        outQ.delete();
        sbQ.delete();
        lastOwner = 1;
        lockOwner = -1;
        @(negedge clk_i);
        checkOutput("reset_outputs",
                    128'({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                          m0_err_o, m1_err_o, spurious_rvalid_o, busy_o}), 128'(0));
        rst_ni = 1'b1;
    endtask

    // Reference model: round-robin with lock and an outstanding limit,
    // evaluated from the request lines seen this cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            int expG;
            expG = -1;
            if (outQ.size() < MAXO) begin
                if (lockOwner >= 0) begin
                    if (mReq[lockOwner]) expG = lockOwner;
                end else if (mReq[0] && mReq[1]) begin
                    expG = 1 - lastOwner;
                end else if (mReq[0]) begin
                    expG = 0;
                end else if (mReq[1]) begin
                    expG = 1;
                end
            end
            checkOutput("grant", 128'({s_req_o, m1_gnt_o, m0_gnt_o}),
                        128'({expG >= 0, expG == 1 && s_gnt_i, expG == 0 && s_gnt_i}));
            checkOutput("payload", {s_addr_o, s_wdata_o, s_we_o, s_be_o, s_atop_o},
                        (expG == 1) ? {mAddr[1], mWdata[1], mWe[1], mBe[1], mAtop[1]}
                                    : {mAddr[0], mWdata[0], mWe[0], mBe[0], mAtop[0]});
            checkOutput("busy", 128'(busy_o), 128'(mReq[0] || mReq[1] || outQ.size() != 0));
            if (s_rvalid_i && outQ.size() != 0) void'(outQ.pop_front());
            if (expG >= 0 && s_gnt_i) begin
                outQ.push_back(expG);
                lastOwner = expG;
                lockOwner = mLock[expG] ? expG : -1;
            end
        end
    end

    // Monitor: every expected response must appear in the cycle it was issued.
    always @(negedge clk_i) begin
        if (rst_ni && (sbQ.size() != 0 || m0_rvalid_o || m1_rvalid_o || spurious_rvalid_o)) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_resp", 128'({spurious_rvalid_o, m1_rvalid_o, m0_rvalid_o}), 128'(0));
            end else begin
                resp_t e;
                e = sbQ.pop_front();
                if (e.spur) begin
                    checkOutput("spurious", 128'({spurious_rvalid_o, m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}),
                                128'(5'b10000));
                end else begin
                    checkOutput("route", 128'({spurious_rvalid_o, m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}),
                                128'({1'b0, e.owner, ~e.owner, e.owner & e.err, ~e.owner & e.err}));
                    checkOutput("rdata", 128'({m1_rdata_o, m0_rdata_o}), 128'({e.rdata, e.rdata}));
                end
            end
        end
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            mReq[m] = 1'b0;
            mLock[m] = 1'b0;
            pend[m] = 1'b0;
            newPayload(m);
            mAddr[m] = stAddr[m]; mWe[m] = stWe[m]; mBe[m] = stBe[m];
            mWdata[m] = stWdata[m]; mAtop[m] = stAtop[m];
        end
        doReset();

        // Single master read, response two cycles after the grant.
        stAddr[0] = 32'h100;
        stWe[0]   = 1'b0;
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        drain();

        // Contention from reset: alternating grants starting with m0.
        doReset();
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 1, 1, $urandom, 0);
        drain();

        // Lock held by m1, then released.
        applyStimulus(0, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 1, $urandom, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, $urandom, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, $urandom, 0);
        applyStimulus(0, 1, 0, 0, 1, 1, $urandom, 0);
        drain();

        // Full: no grant while full, nor in the cycle the response frees a slot.
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, $urandom, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        drain();

        // Error routed to m1, then a response with nothing outstanding.
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h12345678, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0);
        drain();

        // Reset with one transaction outstanding; its late response is spurious.
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic. Requests are held until the DUT grants them.
        for (int c = 0; c < 3000; c++) begin
            bit lk [2];
            bit rv;
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && ($urandom % 2 == 0)) begin
                    pend[m] = 1'b1;
                    newPayload(m);
                end
                lk[m] = pend[m] ? (mReq[m] ? mLock[m] : ($urandom % 5 == 0)) : 1'b0;
            end
            rv = (outQ.size() != 0) ? ($urandom % 3 != 0) : ($urandom % 16 == 0);
            applyStimulus(pend[0], pend[1], lk[0], lk[1], ($urandom % 4 != 0), rv,
                          $urandom, ($urandom % 6 == 0));
            @(negedge clk_i);
            #1;
            if (m0_gnt_o) pend[0] = 1'b0;
            if (m1_gnt_o) pend[1] = 1'b0;
        end
        drain();
        checkOutput("scoreboard_empty", 128'(sbQ.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
